// File: rtl/la_pwrseq_pkg.sv
// Shared definitions for the power-domain sequencer: state encoding and timer sizing.
package la_pwrseq_pkg;

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_UP      = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_REL_ISO = 3'd3;
  localparam logic [2:0] ST_REL_RST = 3'd4;
  localparam logic [2:0] ST_ON      = 3'd5;
  localparam logic [2:0] ST_DOWN    = 3'd6;

  typedef enum logic [2:0] {
    S_OFF     = ST_OFF,
    S_UP      = ST_UP,
    S_SETTLE  = ST_SETTLE,
    S_REL_ISO = ST_REL_ISO,
    S_REL_RST = ST_REL_RST,
    S_ON      = ST_ON,
    S_DOWN    = ST_DOWN
  } state_e;

  // Width needed to hold max(step, settle) - 1; never narrower than one bit.
  function automatic int tmr_width(input int step, input int settle);
    int m;
    m = (step > settle) ? step : settle;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/la_pwrseq_timer.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module la_pwrseq_timer
  import la_pwrseq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/la_pwrseq.sv
// Power-domain sequencer: staged switch enable, then isolation and reset release;
// the reverse on power-down. Every output comes straight from a flop.
module la_pwrseq
  import la_pwrseq_pkg::*;
#(
  parameter string PROP   = "DEFAULT",
  parameter int    N      = 4,
  parameter int    STEP   = 2,
  parameter int    SETTLE = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwr_req,
  output logic [N-1:0] swen,
  output logic         iso,
  output logic         dom_reset,
  output logic         pwr_ack,
  output logic         busy
);

  localparam int TW = tmr_width(STEP, SETTLE);
  localparam logic [TW-1:0] STEP_LD   = TW'(STEP - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   swen_q, swen_d;
  logic           iso_q, iso_d;
  logic           dom_reset_q, dom_reset_d;
  logic           pwr_ack_q, pwr_ack_d;
  logic           busy_q, busy_d;
  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tmr_zero;
  logic [N-1:0]   swen_grow;
  logic [N-1:0]   swen_shrink;

  assign swen_grow   = (swen_q << 1) | N'(1);
  assign swen_shrink = swen_q >> 1;

  la_pwrseq_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    swen_d      = swen_q;
    iso_d       = iso_q;
    dom_reset_d = dom_reset_q;
    pwr_ack_d   = pwr_ack_q;
    busy_d      = busy_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      S_OFF: begin
        if (pwr_req) begin
          swen_d   = N'(1);
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          // A single stage is already fully on, so settling starts immediately.
          if (N == 1) begin
            tmr_val = SETTLE_LD;
            state_d = S_SETTLE;
          end else begin
            tmr_val = STEP_LD;
            state_d = S_UP;
          end
        end
      end
      S_UP: begin
        if (tmr_zero) begin
          swen_d   = swen_grow;
          tmr_load = 1'b1;
          if (swen_grow[N-1]) begin
            tmr_val = SETTLE_LD;
            state_d = S_SETTLE;
          end else begin
            tmr_val = STEP_LD;
          end
        end
      end
      S_SETTLE: begin
        if (tmr_zero) begin
          iso_d   = 1'b0;
          state_d = S_REL_ISO;
        end
      end
      S_REL_ISO: begin
        dom_reset_d = 1'b0;
        state_d     = S_REL_RST;
      end
      S_REL_RST: begin
        pwr_ack_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_ON;
      end
      S_ON: begin
        if (!pwr_req) begin
          pwr_ack_d   = 1'b0;
          iso_d       = 1'b1;
          dom_reset_d = 1'b1;
          busy_d      = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = '0;
          state_d     = S_DOWN;
        end
      end
      S_DOWN: begin
        // Timer enters at zero, so the top stage drops on the first edge here.
        if (tmr_zero) begin
          swen_d   = swen_shrink;
          tmr_load = 1'b1;
          tmr_val  = STEP_LD;
          if (swen_shrink == '0) begin
            busy_d  = 1'b0;
            state_d = S_OFF;
          end
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OFF;
      swen_q      <= '0;
      iso_q       <= 1'b1;
      dom_reset_q <= 1'b1;
      pwr_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      swen_q      <= swen_d;
      iso_q       <= iso_d;
      dom_reset_q <= dom_reset_d;
      pwr_ack_q   <= pwr_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign swen      = swen_q;
  assign iso       = iso_q;
  assign dom_reset = dom_reset_q;
  assign pwr_ack   = pwr_ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_la_pwrseq.sv
// Bench for la_pwrseq: a default instance and an N=1/STEP=1/SETTLE=1 instance,
// each tracked by a timeline model (phase + cycles since the phase began).
module tb_la_pwrseq;

  localparam int AN = 4, AST = 2, ASE = 8;
  localparam int BN = 1, BST = 1, BSE = 1;

  localparam int P_OFF = 0, P_RAMP = 1, P_ON = 2, P_DOWN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, req_a, rst_b, req_b;
  logic [AN-1:0] swen_a;
  logic [BN-1:0] swen_b;
  logic          iso_a, dr_a, ack_a, busy_a;
  logic          iso_b, dr_b, ack_b, busy_b;

  la_pwrseq #(.PROP("DEFAULT"), .N(AN), .STEP(AST), .SETTLE(ASE)) dut_a (
    .clk(clk), .reset(rst_a), .pwr_req(req_a), .swen(swen_a),
    .iso(iso_a), .dom_reset(dr_a), .pwr_ack(ack_a), .busy(busy_a)
  );

  la_pwrseq #(.PROP("CORNER"), .N(BN), .STEP(BST), .SETTLE(BSE)) dut_b (
    .clk(clk), .reset(rst_b), .pwr_req(req_b), .swen(swen_b),
    .iso(iso_b), .dom_reset(dr_b), .pwr_ack(ack_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  int ph[2] = '{P_OFF, P_OFF};
  int kk[2] = '{0, 0};

  function automatic int par_n(input int i);
    return (i == 0) ? AN : BN;
  endfunction
  function automatic int par_st(input int i);
    return (i == 0) ? AST : BST;
  endfunction
  function automatic int par_se(input int i);
    return (i == 0) ? ASE : BSE;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Up takes (N-1)*STEP+SETTLE+2 edges from E0; down takes 1+(N-1)*STEP edges from D0.
  task automatic model_step(input int i, input bit r, input bit q);
    int up, dn;
    up = (par_n(i) - 1) * par_st(i) + par_se(i) + 2;
    dn = 1 + (par_n(i) - 1) * par_st(i);
    if (r) begin
      ph[i] = P_OFF;
    end else begin
      case (ph[i])
        P_OFF:  if (q) begin ph[i] = P_RAMP; kk[i] = 0; end
        P_RAMP: begin kk[i]++; if (kk[i] == up) ph[i] = P_ON; end
        P_ON:   if (!q) begin ph[i] = P_DOWN; kk[i] = 0; end
        default: begin kk[i]++; if (kk[i] == dn) ph[i] = P_OFF; end
      endcase
    end
  endtask

  task automatic compare(input int i, input int sw, input int iso, input int dr,
                         input int ack, input int busy);
    int n, st, t, cnt, e_iso, e_dr, e_ack, e_busy;
    n  = par_n(i);
    st = par_st(i);
    t  = (n - 1) * st + par_se(i);
    case (ph[i])
      P_OFF:  begin cnt = 0; e_iso = 1; e_dr = 1; e_ack = 0; e_busy = 0; end
      P_RAMP: begin
        cnt    = (kk[i] / st + 1 < n) ? kk[i] / st + 1 : n;
        e_iso  = (kk[i] < t) ? 1 : 0;
        e_dr   = (kk[i] < t + 1) ? 1 : 0;
        e_ack  = 0;
        e_busy = 1;
      end
      P_ON:   begin cnt = n; e_iso = 0; e_dr = 0; e_ack = 1; e_busy = 0; end
      default: begin
        cnt    = (kk[i] == 0) ? n : n - 1 - (kk[i] - 1) / st;
        e_iso  = 1; e_dr = 1; e_ack = 0; e_busy = 1;
      end
    endcase
    chk($sformatf("inst%0d swen", i), sw, (1 << cnt) - 1);
    chk($sformatf("inst%0d iso", i), iso, e_iso);
    chk($sformatf("inst%0d dom_reset", i), dr, e_dr);
    chk($sformatf("inst%0d pwr_ack", i), ack, e_ack);
    chk($sformatf("inst%0d busy", i), busy, e_busy);
    chk($sformatf("inst%0d thermometer", i), ((sw + 1) & sw) == 0 ? 1 : 0, 1);
    chk($sformatf("inst%0d iso/dom_reset invariant", i),
        ((iso == 0 && sw != (1 << n) - 1) || (dr == 0 && iso != 0)) ? 1 : 0, 0);
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, req_a);
    model_step(1, rst_b, req_b);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      compare(0, int'(swen_a), int'(iso_a), int'(dr_a), int'(ack_a), int'(busy_a));
      compare(1, int'(swen_b), int'(iso_b), int'(dr_b), int'(ack_b), int'(busy_b));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; req_a = 1'b1;
    rst_b = 1'b1; req_b = 1'b0;
    step(3);
    chk("reset swen", int'(swen_a), 0);
    chk("reset iso", int'(iso_a), 1);
    chk("reset dom_reset", int'(dr_a), 1);
    chk("reset pwr_ack", int'(ack_a), 0);
    chk("reset busy", int'(busy_a), 0);

    // Power-up: first edge after release is E0.
    rst_a = 1'b0;
    step(1);
    chk("up swen E0", int'(swen_a), 4'b0001);
    step(2);
    chk("up swen E0+2", int'(swen_a), 4'b0011);
    step(4);
    chk("up swen E0+6", int'(swen_a), 4'b1111);
    step(7);
    chk("up iso E0+13", int'(iso_a), 1);
    step(1);
    chk("up iso E0+14", int'(iso_a), 0);
    chk("up dom_reset E0+14", int'(dr_a), 1);
    step(1);
    chk("up dom_reset E0+15", int'(dr_a), 0);
    chk("up pwr_ack E0+15", int'(ack_a), 0);
    step(1);
    chk("up pwr_ack E0+16", int'(ack_a), 1);
    chk("up busy E0+16", int'(busy_a), 0);

    // Power-down.
    req_a = 1'b0;
    step(1);
    chk("down pwr_ack D0", int'(ack_a), 0);
    chk("down iso D0", int'(iso_a), 1);
    chk("down swen D0", int'(swen_a), 4'b1111);
    step(1);
    chk("down swen D0+1", int'(swen_a), 4'b0111);
    step(5);
    chk("down swen D0+6", int'(swen_a), 4'b0001);
    chk("down busy D0+6", int'(busy_a), 1);
    step(1);
    chk("down swen D0+7", int'(swen_a), 4'b0000);
    chk("down busy D0+7", int'(busy_a), 0);

    // Request withdrawn at E0+3: ramp completes, then DOWN.
    req_a = 1'b1;
    step(3);
    req_a = 1'b0;
    step(14);
    chk("withdraw pwr_ack E0+16", int'(ack_a), 1);
    step(1);
    chk("withdraw pwr_ack E0+17", int'(ack_a), 0);
    step(7);
    chk("withdraw swen E0+24", int'(swen_a), 0);
    chk("withdraw busy E0+24", int'(busy_a), 0);

    // Reset at E0+10 during SETTLE.
    req_a = 1'b1;
    step(10);
    chk("settle swen E0+9", int'(swen_a), 4'b1111);
    rst_a = 1'b1;
    step(1);
    chk("midreset swen", int'(swen_a), 0);
    chk("midreset iso", int'(iso_a), 1);
    chk("midreset busy", int'(busy_a), 0);
    rst_a = 1'b0;

    // Corner instance: N=1, STEP=1, SETTLE=1.
    rst_b = 1'b0; req_b = 1'b1;
    step(1);
    chk("corner swen E0", int'(swen_b), 1);
    chk("corner iso E0", int'(iso_b), 1);
    step(1);
    chk("corner iso E0+1", int'(iso_b), 0);
    step(1);
    chk("corner dom_reset E0+2", int'(dr_b), 0);
    chk("corner pwr_ack E0+2", int'(ack_b), 0);
    step(1);
    chk("corner pwr_ack E0+3", int'(ack_b), 1);

    // Random requests and occasional resets on both instances.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) req_a = ~req_a;
      if ($urandom_range(0, 11) == 0) req_b = ~req_b;
      rst_a = ($urandom_range(0, 249) == 0);
      rst_b = ($urandom_range(0, 249) == 0);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_pwrseq.md
# la_pwrseq

Power-domain sequencer for the auxlib power-management cells. It turns a single request into a staged, timed enable of N power-switch groups, then releases isolation and domain reset. Its `swen` bits drive the gated-supply buffers and headers directly downstream. Power-down runs the same sequence in reverse. It is the only block allowed to toggle switch enables, isolation and domain reset for one domain.

## Interface

Parameters:
- `PROP`, "DEFAULT": implementation property string, passed through untouched.
- `N`, 4: number of switch stages; N ≥ 1.
- `STEP`, 2: cycles between consecutive stage enables or disables; STEP ≥ 1.
- `SETTLE`, 8: cycles to wait after the last stage is enabled before releasing isolation; SETTLE ≥ 1.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high reset.
- `pwr_req` input 1: level request; 1 = domain on, 0 = domain off.
- `swen` output N: switch-stage enables, bit 0 first on and last off.
- `iso` output 1: isolation enable, 1 = isolated.
- `dom_reset` output 1: domain reset, active high.
- `pwr_ack` output 1: 1 only when the domain is fully on and released.
- `busy` output 1: 1 while a ramp-up or ramp-down is in progress.

## Operation

- All outputs are registered.
- Reset values: `swen`=0, `iso`=1, `dom_reset`=1, `pwr_ack`=0, `busy`=0, state OFF, timer 0.
- States: OFF, UP, SETTLE, REL_ISO, REL_RST, ON, DOWN.
- OFF, when `pwr_req`=1: set `swen[0]` and `busy`=1, load timer with STEP-1, go to UP.
- UP: when the timer reaches 0, set the next `swen` bit and reload the timer. Once `swen[N-1]` has been set, load the timer with SETTLE-1 and go to SETTLE.
- SETTLE: when the timer reaches 0, set `iso`=0 and go to REL_ISO.
- REL_ISO: set `dom_reset`=0 and go to REL_RST.
- REL_RST: set `pwr_ack`=1 and `busy`=0, go to ON.
- ON, when `pwr_req`=0: set `pwr_ack`=0, `iso`=1, `dom_reset`=1 and `busy`=1 on the same edge, then go to DOWN.
- DOWN: clear `swen` bits from N-1 down to 0, STEP cycles apart. The first clear happens on the edge after entry. On the edge that clears bit 0, set `busy`=0 and go to OFF.
- N=1: UP moves straight to SETTLE with the SETTLE load.
- `pwr_req` is ignored in every state except OFF and ON. A sequence always runs to completion; a reversed request takes effect only after OFF or ON is reached.
- `swen` is thermometer-coded at all times: bit i is never 1 while bit i-1 is 0.
- `iso`=0 implies `swen` is all ones. `dom_reset`=0 implies `iso`=0.
- Timer width is $clog2(max(STEP,SETTLE)). It counts down and never wraps.
- Reset wins over every state. One cycle of `reset` mid-ramp returns all outputs to their reset values on that edge, with no staged teardown.

## Timing

- E0 is the edge that samples `pwr_req`=1 in OFF.
- `swen[i]` rises after edge E0 + i·STEP.
- `iso` falls after edge E0 + (N-1)·STEP + SETTLE.
- `dom_reset` falls one edge later, and `pwr_ack` rises one edge after that.
- Up latency is (N-1)·STEP + SETTLE + 2 edges. Defaults give 16.
- D0 is the edge that samples `pwr_req`=0 in ON. `pwr_ack`, `iso` and `dom_reset` change after D0.
- `swen[N-1]` clears after D0+1, and `swen[0]` clears after D0 + 1 + (N-1)·STEP. Defaults give D0+7.
- OFF is reached on that same edge. A new request is accepted at the earliest one edge later.

## Structure

- Shared package `la_pwrseq_pkg` holds the state encoding localparams and the timer-width function.
- One sub-module, `la_pwrseq_timer`: a loadable down-counter with a zero flag. The FSM and the `swen` shift logic stay in the top module.
- Port names follow the auxlib supply-cell conventions, so `swen[i]` wires straight to stage i of the downstream power buffers.

## Test plan

Defaults apply (N=4, STEP=2, SETTLE=8) unless a scenario says otherwise.
- **Reset:** hold `reset` for 3 cycles with `pwr_req`=1 → `swen`=0000, `iso`=1, `dom_reset`=1, `pwr_ack`=0, `busy`=0. After release, `swen` goes to 0001 on the first edge.
- **Power-up:** pulse `pwr_req` high at E0 → `swen` steps 0001, 0011, 0111, 1111 after E0, E0+2, E0+4, E0+6. `iso` falls after E0+14, `dom_reset` after E0+15, `pwr_ack` rises after E0+16.
- **Power-down:** drop `pwr_req` at D0 in ON → `pwr_ack`=0, `iso`=1, `dom_reset`=1 after D0. `swen` steps 0111, 0011, 0001, 0000 after D0+1, +3, +5, +7, and `busy` falls after D0+7.
- **Request withdrawn mid-ramp:** drop `pwr_req` at E0+3 → ramp-up still completes with `pwr_ack`=1 at E0+16. DOWN starts at the next edge.
- **Reset mid-SETTLE:** assert `reset` at E0+10 → all outputs take their reset values after that edge, with no intermediate `swen` patterns.
- **Parameter corners:** N=1, STEP=1, SETTLE=1 → `swen`=1 after E0, `iso` falls after E0+1, `pwr_ack` rises after E0+3. Check the thermometer and `iso`/`dom_reset` invariants every cycle in every scenario.
